systolic_result_drain: RTL and testbench

//  Reads the accumulated C_out values of the N x N systolic PE array after a matrix job.
//  It is the consumer end of the PE result interface: the array produces results, this

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/systolic_result_drain.sv | 119 +++++++++++
 tb/tb_systolic_result_drain.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array, its PEs and the result drain.
//   N      array dimension (N x N PEs, N*N results per job)
//   A_W    operand width fed into the PEs
//   C_W    accumulated result width (PE C_out)
//   IDX_W  row/column index width
package systolic_pkg;
  localparam int N     = 4;
  localparam int A_W   = 16;
  localparam int C_W   = 33;
  localparam int IDX_W = $clog2(N);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} drain_state_t;

  // One beat on the host-side result stream.
  typedef struct packed {
    logic [C_W-1:0]   data;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic             last;
  } drain_beat_t;
endpackage

// File: rtl/systolic_result_drain.sv
// Result drain for the N x N systolic array.
// On start (in IDLE) all N*N PE results are snapshotted into a local bank and
// arr_clr pulses for one cycle so the array can begin its next job. The bank is
// then streamed row-major over valid/ready; done pulses once the last beat is taken.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             capture request, honoured only in IDLE
//   c_flat            packed PE results, PE(r,c) at [(r*N+c)*C_W +: C_W]
//   busy              high while streaming or finishing
//   arr_clr           one-cycle clear pulse to the array after capture
//   out_valid/ready   stream handshake
//   out_data/row/col  current result and its array position
//   out_last          current beat is the final one of the frame
//   done              one-cycle pulse after the final beat is accepted
module systolic_result_drain
  import systolic_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N*N*C_W-1:0]   c_flat,
  output logic                 busy,
  output logic                 arr_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [C_W-1:0]       out_data,
  output logic [IDX_W-1:0]     out_row,
  output logic [IDX_W-1:0]     out_col,
  output logic                 out_last,
  output logic                 done
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(N - 1);

  drain_state_t     state, state_nxt;
  logic [IDX_W-1:0] row, col;   // row-major beat index kept as (row, col)
  logic [C_W-1:0]   bank [N][N];
  logic             at_last, xfer;
  drain_beat_t      beat;

  assign at_last = (row == MAX_IDX) && (col == MAX_IDX);
  assign xfer    = (state == STREAM) && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = STREAM;
      STREAM:  if (xfer && at_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture bank, beat index and the array clear pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      row     <= '0;
      col     <= '0;
      arr_clr <= 1'b0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          bank[r][c] <= '0;
    end else begin
      arr_clr <= 1'b0;
      if (state == IDLE && start) begin
        row     <= '0;
        col     <= '0;
        arr_clr <= 1'b1;
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            bank[r][c] <= c_flat[(r*N+c)*C_W +: C_W];
      end else if (xfer && !at_last) begin
        // Final beat leaves the index parked; the next capture rewinds it.
        if (col == MAX_IDX) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Outputs decoded from state; beat fields are zero outside STREAM
  always_comb begin
    beat      = '0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        beat.data = bank[row][col];
        beat.row  = row;
        beat.col  = col;
        beat.last = at_last;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign out_data = beat.data;
  assign out_row  = beat.row;
  assign out_col  = beat.col;
  assign out_last = beat.last;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain: stimulus pushes the expected beats
// of each frame, a negedge monitor pops and compares every accepted beat and
// checks that stalled beats hold steady.
module tb_systolic_result_drain;
  import systolic_pkg::*;

  localparam int NN = N * N;

  logic               clk = 1'b0;
  logic               rst, start, out_ready;
  logic [NN*C_W-1:0]  c_flat;
  logic               busy, arr_clr, out_valid, out_last, done;
  logic [C_W-1:0]     out_data;
  logic [IDX_W-1:0]   out_row, out_col;

  systolic_result_drain dut (
    .clk(clk), .rst(rst), .start(start), .c_flat(c_flat),
    .busy(busy), .arr_clr(arr_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, beats = 0, clr_cnt = 0, done_cnt = 0;
  int clr_cyc[$];
  drain_beat_t q[$];
  drain_beat_t held;
  bit stall_pend = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pe(input int r, input int c, input logic [C_W-1:0] v);
    c_flat[(r*N+c)*C_W +: C_W] = v;
  endtask

  // PE(r,c) = 100 + 4r + c
  task automatic load_base();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        set_pe(r, c, C_W'(100 + 4*r + c));
  endtask

  task automatic push_frame();
    drain_beat_t b;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        b.data = c_flat[(r*N+c)*C_W +: C_W];
        b.row  = IDX_W'(r);
        b.col  = IDX_W'(c);
        b.last = (r == N-1) && (c == N-1);
        q.push_back(b);
      end
  endtask

  task automatic wait_done(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    drain_beat_t e;
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", 64'(out_data), 64'(held.data));
        chk("stall_rcl", 64'({out_row, out_col, out_last}), 64'({held.row, held.col, held.last}));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_beat got=%0h want=none", out_data);
        end else begin
          e = q.pop_front();
          chk("beat_data", 64'(out_data), 64'(e.data));
          chk("beat_row",  64'(out_row),  64'(e.row));
          chk("beat_col",  64'(out_col),  64'(e.col));
          chk("beat_last", 64'(out_last), 64'(e.last));
        end
        beats++;
      end
      stall_pend = out_valid && !out_ready;
      held.data = out_data; held.row = out_row; held.col = out_col; held.last = out_last;
      if (arr_clr) begin clr_cnt++; clr_cyc.push_back(cyc); end
      if (done) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit [5:0] pat = 6'b101001;  // ready per cycle: 1,0,0,1,0,1
    int b0, c0, d0, n0, dl;

    rst = 1'b1; start = 1'b0; out_ready = 1'b0; c_flat = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_busy",  64'(busy), 0);
    chk("rst_done",  64'(done), 0);
    chk("rst_clr",   64'(arr_clr), 0);
    chk("rst_data",  64'(out_data), 0);
    chk("rst_last",  64'(out_last), 0);

    // 1: full-speed frame with latency checks
    tick();
    load_base(); out_ready = 1'b1; push_frame();
    c0 = clr_cnt; d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;          // cycle k+1
    @(negedge clk);
    chk("t1_clr_k1", 64'(arr_clr), 1);
    chk("t1_valid_k1", 64'(out_valid), 1);
    chk("t1_busy_k1", 64'(busy), 1);
    tick(); @(negedge clk);                       // k+2
    chk("t1_clr_k2", 64'(arr_clr), 0);
    repeat (14) tick();                           // k+16
    @(negedge clk);
    chk("t1_last_k16", 64'(out_last), 1);
    chk("t1_data_k16", 64'(out_data), 115);
    tick(); @(negedge clk);                       // k+17
    chk("t1_done_k17", 64'(done), 1);
    chk("t1_valid_k17", 64'(out_valid), 0);
    tick(); @(negedge clk);                       // k+18
    chk("t1_busy_k18", 64'(busy), 0);
    chk("t1_done_k18", 64'(done), 0);
    chk("t1_q_empty", 64'(q.size()), 0);
    chk("t1_clr_cnt", 64'(clr_cnt - c0), 1);
    chk("t1_done_cnt", 64'(done_cnt - d0), 1);

    // 2: backpressure pattern
    tick();
    push_frame();
    b0 = beats; d0 = done_cnt;
    out_ready = pat[0];
    start = 1'b1; tick(); start = 1'b0;
    ok = 1'b0;
    for (int i = 1; i < 300; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
      tick();
      out_ready = pat[i % 6];
    end
    chk("t2_done_seen", 64'(ok), 1);
    chk("t2_beats", 64'(beats - b0), 16);
    chk("t2_q_empty", 64'(q.size()), 0);
    tick(); out_ready = 1'b1;
    @(negedge clk);
    chk("t2_done_cnt", 64'(done_cnt - d0), 1);

    // 3: start re-pulsed mid-stream, c_flat cleared after capture
    tick();
    load_base(); push_frame();
    c0 = clr_cnt; d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    c_flat = '0;
    repeat (2) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(60, ok);
    chk("t3_done_seen", 64'(ok), 1);
    tick(); tick(); @(negedge clk);
    chk("t3_q_empty", 64'(q.size()), 0);
    chk("t3_clr_cnt", 64'(clr_cnt - c0), 1);
    chk("t3_done_cnt", 64'(done_cnt - d0), 1);
    chk("t3_idle", 64'(busy), 0);

    // 4: reset while idx=5, then restart
    tick();
    load_base(); push_frame();
    start = 1'b1; tick(); start = 1'b0;          // k+1, idx 0
    repeat (5) tick();                            // k+6, idx 5
    chk("t4_row_idx5", 64'(out_row), 1);
    chk("t4_col_idx5", 64'(out_col), 1);
    rst = 1'b1; q.delete();
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("t4_valid", 64'(out_valid), 0);
    chk("t4_busy",  64'(busy), 0);
    chk("t4_done",  64'(done), 0);
    chk("t4_clr",   64'(arr_clr), 0);
    tick();
    push_frame();
    start = 1'b1; tick(); start = 1'b0;
    @(negedge clk);
    chk("t4_restart_row", 64'(out_row), 0);
    chk("t4_restart_col", 64'(out_col), 0);
    wait_done(60, ok);
    chk("t4_done_seen", 64'(ok), 1);
    chk("t4_q_empty", 64'(q.size()), 0);

    // 5: full-width extreme values
    tick(); tick();
    load_base();
    set_pe(0, 0, 33'h1_FFFF_FFFF);
    set_pe(3, 3, 33'h1_0000_0000);
    push_frame();
    start = 1'b1; tick(); start = 1'b0;
    @(negedge clk);
    chk("t5_first", 64'(out_data), 64'h1_FFFF_FFFF);
    wait_done(60, ok);
    chk("t5_done_seen", 64'(ok), 1);
    chk("t5_q_empty", 64'(q.size()), 0);

    // 6: start held high, back-to-back frames
    tick(); tick();
    load_base();
    push_frame(); push_frame(); push_frame();
    c0 = clr_cnt; d0 = done_cnt; n0 = clr_cyc.size(); dl = 0;
    start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (done) dl++;
      if (dl == 3) begin ok = 1'b1; break; end
      tick();
    end
    tick(); start = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("t6_frames", 64'(ok), 1);
    chk("t6_clr_cnt", 64'(clr_cnt - c0), 3);
    chk("t6_done_cnt", 64'(done_cnt - d0), 3);
    chk("t6_q_empty", 64'(q.size()), 0);
    if (clr_cyc.size() >= n0 + 3) begin
      chk("t6_period_a", 64'(clr_cyc[n0+1] - clr_cyc[n0]), 18);
      chk("t6_period_b", 64'(clr_cyc[n0+2] - clr_cyc[n0+1]), 18);
    end else begin
      checks++; errors++;
      $display("FAIL t6_clr_list got=%0d want=%0d", clr_cyc.size() - n0, 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
